mp_regfile_sb: RTL and testbench
================================

Name: mp_regfile_sb

Overview:
Parametrised multi-port general register file with an integrated busy-bit scoreboard. It serves NRD combinational read ports and two prioritised write ports. Same-cycle write-to-read bypass applies to every read port. Per-register pending bits are set when a producer instruction issues and cleared at its writeback, so the pipeline's hazard unit can stall or forward without keeping its own register tracking.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; depth NREG = 2**ADDR_W
NRD, 2, number of read ports (1..4)
ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never busy

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all registers and busy bits
rd_addr  input  NRD*ADDR_W  packed read addresses, port i at bits [i*ADDR_W +: ADDR_W]
rd_data  output  NRD*DATA_W  packed read data, combinational, with bypass
rd_busy  output  NRD  busy flag for each read address after bypass
wa_en  input  1  write port A enable (higher priority)
wa_addr  input  ADDR_W  write port A address
wa_data  input  DATA_W  write port A data
wb_en  input  1  write port B enable
wb_addr  input  ADDR_W  write port B address
wb_data  input  DATA_W  write port B data
iss_en  input  1  issue strobe: mark iss_addr pending
iss_addr  input  ADDR_W  destination register of the issuing instruction
busy_vec  output  NREG  current scoreboard bits (registered state, no bypass)
wr_cnt  output  16  saturating count of committed register writes

Behaviour:
- Reset (reset=1 at an edge): all NREG registers become 0, busy_vec becomes 0, wr_cnt becomes 0. Writes and issues in that cycle are ignored. rd_data reads 0 for all ports from the next cycle.
- Write rule: at the edge, a register is written if its enable is set and, when ZERO_REG=1, its address is nonzero.
  - A and B to different addresses: both registers are written.
  - A and B to the same address: A's data is stored, and the two writes count as one commit.
- Read (combinational), per port i:
  - If ZERO_REG=1 and rd_addr_i==0: output 0.
  - Else if wa_en and wa_addr==rd_addr_i: output wa_data.
  - Else if wb_en and wb_addr==rd_addr_i: output wb_data.
  - Else: output the stored value.
- Scoreboard, evaluated per register r at the edge:
  - Set when iss_en and iss_addr==r.
  - Cleared when a write targets r and no issue targets r that cycle.
  - Simultaneous issue and write to r: busy stays or becomes 1, because the new producer supersedes the old one.
  - With ZERO_REG=1, register 0 is never set.
- rd_busy_i (combinational):
  - Is busy_vec[rd_addr_i] AND NOT (a same-cycle write to rd_addr_i).
  - Bypass covers the in-flight value, so a same-cycle iss_en does not raise rd_busy.
  - Forced to 0 for address 0 when ZERO_REG=1.
- wr_cnt: incremented by the number of distinct registers written in that cycle (0, 1 or 2). Saturates at 16'hFFFF with no wrap.
- Latency:
  - A write is visible on rd_data in the same cycle via bypass and from stored state the next cycle.
  - A busy bit changes one cycle after its issue or write.
- Disabled writes have no effect, whatever their addresses or data.
- Reset asserted mid-operation discards pending busy bits. Writebacks of in-flight producers that arrive later write normally, and clear bits that are already clear, which is harmless.

Test Plan:
1. Reset, then read all 32 addresses on both ports -> every rd_data=0, busy_vec=0, wr_cnt=0.
2. wa_en=1, wa_addr=5, wa_data=32'hDEADBEEF with rd_addr0=5 in the same cycle:
   - Same cycle: rd_data0=32'hDEADBEEF.
   - After the edge with wa_en=0: still 32'hDEADBEEF, wr_cnt=1.
3. Write collision: wa to address 7 with 32'h1111, wb to address 7 with 32'h2222, same cycle -> register 7 holds 32'h1111, wr_cnt increases by 1. Then wa to 8 and wb to 9 together -> both written, wr_cnt increases by 2.
4. Zero register: wa_en=1, wa_addr=0, wa_data=32'hFFFFFFFF and iss_en=1, iss_addr=0 -> rd_data of address 0 is 0, busy_vec[0]=0, wr_cnt unchanged.
5. Scoreboard sequence:
   - Issue to 3 -> next cycle busy_vec[3]=1 and rd_busy=1 when reading 3.
   - Cycle with wb write to 3 (32'h42) -> same cycle rd_busy=0 and rd_data=32'h42; next cycle busy_vec[3]=0.
   - Issue and write to 3 in the same cycle -> busy_vec[3]=1 afterwards.
6. Reset mid-operation: registers 1..4 written and 2, 6 busy, then reset=1 for one cycle while wa writes 1 -> all registers 0, busy_vec=0, write dropped. Also preload wr_cnt to 16'hFFFE and do 2 writes -> wr_cnt=16'hFFFF and holds.

Source files
------------

// File: rtl/mp_regfile_sb_if.sv
// Bundle of register-file ports: read ports, two write ports, issue strobe and scoreboard view.
// All request fields are level inputs sampled on the rising clock edge; there is no back-pressure.
interface mp_regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
);
  localparam int NREG = 1 << ADDR_W;

  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  wa_en;
  logic [ADDR_W-1:0]     wa_addr;
  logic [DATA_W-1:0]     wa_data;
  logic                  wb_en;
  logic [ADDR_W-1:0]     wb_addr;
  logic [DATA_W-1:0]     wb_data;
  logic                  iss_en;
  logic [ADDR_W-1:0]     iss_addr;
  logic [NREG-1:0]       busy_vec;
  logic [15:0]           wr_cnt;

  modport master (
    output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, iss_en, iss_addr,
    input  rd_data, rd_busy, busy_vec, wr_cnt
  );

  modport slave (
    input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, iss_en, iss_addr,
    output rd_data, rd_busy, busy_vec, wr_cnt
  );
endinterface

// File: rtl/mp_regfile_sb.sv
// Multi-port register file with write-to-read bypass, per-register busy scoreboard
// and a saturating committed-write counter.
module mp_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             reset,
  mp_regfile_sb_if.slave   bus
);
   localparam int NREG = 1 << ADDR_W;

   logic [DATA_W-1:0]     r_regs [NREG];
   logic [NREG-1:0]       r_busy;
   logic [15:0]           r_wr_cnt;

   logic                  w_wa_ok;
   logic                  w_wb_ok;
   logic                  w_wb_commit;
   logic [1:0]            w_n_wr;
   logic [16:0]           w_cnt_sum;
   logic [15:0]           w_cnt_nxt;
   logic [NREG-1:0]       w_busy_nxt;
   logic [NRD*DATA_W-1:0] w_rd_data;
   logic [NRD-1:0]        w_rd_busy;

   assign w_wa_ok     = bus.wa_en && !(ZERO_REG != 0 && bus.wa_addr == '0);
   assign w_wb_ok     = bus.wb_en && !(ZERO_REG != 0 && bus.wb_addr == '0);
   // A colliding B write is dropped so the pair commits once with A's data.
   assign w_wb_commit = w_wb_ok && !(w_wa_ok && bus.wb_addr == bus.wa_addr);
   assign w_n_wr      = {1'b0, w_wa_ok} + {1'b0, w_wb_commit};
   assign w_cnt_sum   = {1'b0, r_wr_cnt} + {15'd0, w_n_wr};
   assign w_cnt_nxt   = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];

   always_comb begin
      logic [ADDR_W-1:0] a;
      a         = '0;
      w_rd_data = '0;
      w_rd_busy = '0;
      for (int i = 0; i < NRD; i++) begin
         a = bus.rd_addr[i*ADDR_W +: ADDR_W];
         if (ZERO_REG != 0 && a == '0) begin
            w_rd_data[i*DATA_W +: DATA_W] = '0;
            w_rd_busy[i]                  = 1'b0;
         end else begin
            if (bus.wa_en && bus.wa_addr == a)
               w_rd_data[i*DATA_W +: DATA_W] = bus.wa_data;
            else if (bus.wb_en && bus.wb_addr == a)
               w_rd_data[i*DATA_W +: DATA_W] = bus.wb_data;
            else
               w_rd_data[i*DATA_W +: DATA_W] = r_regs[a];
            // The bypassed value is the one the reader wanted, so a landing write hides busy.
            w_rd_busy[i] = r_busy[a] && !((w_wa_ok && bus.wa_addr == a) ||
                                          (w_wb_ok && bus.wb_addr == a));
         end
      end
   end

   always_comb begin
      w_busy_nxt = r_busy;
      for (int r = 0; r < NREG; r++) begin
         if ((w_wa_ok && bus.wa_addr == ADDR_W'(r)) || (w_wb_ok && bus.wb_addr == ADDR_W'(r)))
            w_busy_nxt[r] = 1'b0;
         // A fresh issue supersedes any older producer writing back this cycle.
         if (bus.iss_en && bus.iss_addr == ADDR_W'(r))
            w_busy_nxt[r] = 1'b1;
      end
      if (ZERO_REG != 0)
         w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NREG; r++)
            r_regs[r] <= '0;
         r_busy   <= '0;
         r_wr_cnt <= '0;
      end else begin
         if (w_wa_ok)
            r_regs[bus.wa_addr] <= bus.wa_data;
         if (w_wb_commit)
            r_regs[bus.wb_addr] <= bus.wb_data;
         r_busy   <= w_busy_nxt;
         r_wr_cnt <= w_cnt_nxt;
      end
   end

   assign bus.rd_data  = w_rd_data;
   assign bus.rd_busy  = w_rd_busy;
   assign bus.busy_vec = r_busy;
   assign bus.wr_cnt   = r_wr_cnt;
endmodule

// File: tb/tb_mp_regfile_sb.sv
// Randomised scoreboard bench for mp_regfile_sb against an array-based reference model.
`timescale 1ns/1ps
module tb_mp_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NRD = 2;
  localparam int NREG = 32;

  typedef struct {
    int                 tag;
    logic [NRD*DW-1:0]  rd_data;
    logic [NRD-1:0]     rd_busy;
    logic [NREG-1:0]    busy_vec;
    logic [15:0]        wr_cnt;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mp_regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) bus ();

  mp_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .ZERO_REG(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // reference model state
  logic [DW-1:0] mdl_regs [NREG];
  bit            mdl_busy [NREG];
  int            mdl_cnt;

  // stimulus for the current cycle
  bit            t_rst;
  bit            t_wa_en, t_wb_en, t_iss_en;
  logic [AW-1:0] t_wa_addr, t_wb_addr, t_iss_addr;
  logic [DW-1:0] t_wa_data, t_wb_data;
  logic [AW-1:0] t_rd [NRD];

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   tag   = 0;

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (t_wa_en && t_wa_addr == a) return t_wa_data;
    if (t_wb_en && t_wb_addr == a) return t_wb_data;
    return mdl_regs[a];
  endfunction

  function automatic bit exp_rbusy(input logic [AW-1:0] a);
    bit landing;
    if (a == 0) return 1'b0;
    landing = (t_wa_en && t_wa_addr == a) || (t_wb_en && t_wb_addr == a);
    return mdl_busy[a] && !landing;
  endfunction

  task automatic set_idle();
    t_rst = 0; t_wa_en = 0; t_wb_en = 0; t_iss_en = 0;
    t_wa_addr = 0; t_wb_addr = 0; t_iss_addr = 0;
    t_wa_data = 0; t_wb_data = 0;
    for (int i = 0; i < NRD; i++) t_rd[i] = 0;
  endtask

  // driver: apply one cycle, queue expectations, then advance the model at the edge
  task automatic step(input bit chk);
    exp_t e;
    int   n;
    reset        = t_rst;
    bus.wa_en    = t_wa_en;  bus.wa_addr  = t_wa_addr;  bus.wa_data = t_wa_data;
    bus.wb_en    = t_wb_en;  bus.wb_addr  = t_wb_addr;  bus.wb_data = t_wb_data;
    bus.iss_en   = t_iss_en; bus.iss_addr = t_iss_addr;
    for (int i = 0; i < NRD; i++) bus.rd_addr[i*AW +: AW] = t_rd[i];
    if (chk) begin
      e.tag = tag++;
      for (int i = 0; i < NRD; i++) begin
        e.rd_data[i*DW +: DW] = exp_read(t_rd[i]);
        e.rd_busy[i]          = exp_rbusy(t_rd[i]);
      end
      for (int r = 0; r < NREG; r++) e.busy_vec[r] = mdl_busy[r];
      e.wr_cnt = 16'(mdl_cnt);
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (t_rst) begin
      for (int r = 0; r < NREG; r++) begin mdl_regs[r] = 0; mdl_busy[r] = 0; end
      mdl_cnt = 0;
    end else begin
      n = 0;
      if (t_wa_en && t_wa_addr != 0) begin
        mdl_regs[t_wa_addr] = t_wa_data; mdl_busy[t_wa_addr] = 0; n++;
      end
      if (t_wb_en && t_wb_addr != 0) begin
        mdl_busy[t_wb_addr] = 0;
        if (!(t_wa_en && t_wa_addr == t_wb_addr)) begin
          mdl_regs[t_wb_addr] = t_wb_data; n++;
        end
      end
      if (t_iss_en && t_iss_addr != 0) mdl_busy[t_iss_addr] = 1;
      mdl_cnt = (mdl_cnt + n > 65535) ? 65535 : mdl_cnt + n;
    end
    #1;
  endtask

  // monitor: compare every queued expectation against the DUT mid-cycle
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.rd_data !== e.rd_data) begin
        n_err++;
        $display("FAIL rd_data tag=%0d got %h exp %h", e.tag, bus.rd_data, e.rd_data);
      end
      n_cmp++;
      if (bus.rd_busy !== e.rd_busy) begin
        n_err++;
        $display("FAIL rd_busy tag=%0d got %b exp %b", e.tag, bus.rd_busy, e.rd_busy);
      end
      n_cmp++;
      if (bus.busy_vec !== e.busy_vec) begin
        n_err++;
        $display("FAIL busy_vec tag=%0d got %h exp %h", e.tag, bus.busy_vec, e.busy_vec);
      end
      n_cmp++;
      if (bus.wr_cnt !== e.wr_cnt) begin
        n_err++;
        $display("FAIL wr_cnt tag=%0d got %h exp %h", e.tag, bus.wr_cnt, e.wr_cnt);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < NREG; r++) begin mdl_regs[r] = 0; mdl_busy[r] = 0; end
    mdl_cnt = 0;
    set_idle();
    t_rst = 1; step(0); step(0);
    set_idle();

    // reset state on every address
    for (int a = 0; a < NREG; a++) begin
      t_rd[0] = AW'(a); t_rd[1] = AW'(NREG - 1 - a); step(1);
    end

    // write with same-cycle bypass, then stored value
    t_wa_en = 1; t_wa_addr = 5; t_wa_data = 32'hDEADBEEF; t_rd[0] = 5; step(1);
    set_idle(); t_rd[0] = 5; step(1);

    // collision then dual write
    t_wa_en = 1; t_wa_addr = 7; t_wa_data = 32'h1111;
    t_wb_en = 1; t_wb_addr = 7; t_wb_data = 32'h2222; t_rd[0] = 7; step(1);
    set_idle(); t_wa_en = 1; t_wa_addr = 8; t_wa_data = 32'h8888;
    t_wb_en = 1; t_wb_addr = 9; t_wb_data = 32'h9999; t_rd[0] = 8; t_rd[1] = 9; step(1);
    set_idle(); t_rd[0] = 7; t_rd[1] = 9; step(1);

    // zero register ignores writes and issues
    t_wa_en = 1; t_wa_addr = 0; t_wa_data = 32'hFFFFFFFF;
    t_iss_en = 1; t_iss_addr = 0; step(1);
    set_idle(); step(1);

    // scoreboard sequence on register 3
    t_iss_en = 1; t_iss_addr = 3; t_rd[0] = 3; step(1);
    set_idle(); t_rd[0] = 3; step(1);
    t_wb_en = 1; t_wb_addr = 3; t_wb_data = 32'h42; t_rd[0] = 3; t_rd[1] = 3; step(1);
    set_idle(); t_rd[0] = 3; step(1);
    t_iss_en = 1; t_iss_addr = 3; t_wa_en = 1; t_wa_addr = 3; t_wa_data = 32'h77; t_rd[0] = 3; step(1);
    set_idle(); t_rd[0] = 3; step(1);

    // random traffic, small address range for frequent overlaps
    for (int k = 0; k < 400; k++) begin
      t_rst      = 0;
      t_wa_en    = ($urandom_range(0, 1) == 1);
      t_wb_en    = ($urandom_range(0, 1) == 1);
      t_iss_en   = ($urandom_range(0, 2) == 0);
      t_wa_addr  = AW'($urandom_range(0, 7));
      t_wb_addr  = AW'($urandom_range(0, 7));
      t_iss_addr = AW'($urandom_range(0, 7));
      t_wa_data  = $urandom;
      t_wb_data  = $urandom;
      for (int i = 0; i < NRD; i++) t_rd[i] = AW'($urandom_range(0, 8));
      step(1);
    end

    // reset mid-operation
    set_idle();
    for (int a = 1; a <= 4; a++) begin
      t_wa_en = 1; t_wa_addr = AW'(a); t_wa_data = $urandom; step(1);
    end
    set_idle(); t_iss_en = 1; t_iss_addr = 2; step(1);
    t_iss_addr = 6; step(1);
    set_idle(); t_rst = 1; t_wa_en = 1; t_wa_addr = 1; t_wa_data = 32'hABCD; step(1);
    set_idle();
    for (int a = 0; a < 8; a++) begin t_rd[0] = AW'(a); t_rd[1] = AW'(a + 8); step(1); end
    t_wb_en = 1; t_wb_addr = 2; t_wb_data = 32'h5; t_rd[0] = 2; step(1);
    set_idle(); t_rd[0] = 2; step(1);

    // fill the counter up to 16'hFFFE, then saturate
    set_idle(); t_rst = 1; step(1);
    set_idle();
    for (int k = 0; k < 32767; k++) begin
      t_wa_en = 1; t_wa_addr = AW'($urandom_range(1, 15)); t_wa_data = $urandom;
      t_wb_en = 1; t_wb_addr = AW'($urandom_range(16, 31)); t_wb_data = $urandom;
      step((k % 4096) == 0);
    end
    set_idle(); t_rd[0] = 1; step(1);
    t_wa_en = 1; t_wa_addr = 10; t_wa_data = 32'h10;
    t_wb_en = 1; t_wb_addr = 20; t_wb_data = 32'h20; step(1);
    set_idle(); step(1);
    t_wa_en = 1; t_wa_addr = 11; t_wa_data = 32'h11;
    t_wb_en = 1; t_wb_addr = 21; t_wb_data = 32'h21; step(1);
    set_idle(); t_rd[0] = 11; t_rd[1] = 21; step(1);

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
